// File: rtl/fifo_rd_sched_pkg.sv
// fifo_rd_sched_pkg: shared Gray/binary helpers and output-slot state encoding
package fifo_rd_sched_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_HOLD  = 1'b1
    } slot_e;

    // Operates on a zero-extended pointer, so any width up to 32 bits truncates cleanly
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter whose priority flips to the loser on each pop
module rr_arb2
(
    input  logic       rclk,
    input  logic       rrst_n,
    input  logic [1:0] i_req,
    input  logic       i_adv,
    output logic [1:0] o_grant
);

    logic r_prio;

    // A lone requester always wins; a tie goes to the consumer the pointer favours
    always_comb o_grant = (i_req == 2'b11) ? (r_prio ? 2'b10 : 2'b01) : i_req;

    // After a grant to consumer 0 favour consumer 1 next, and vice versa
    always_ff @(posedge rclk) begin
        if (!rrst_n) r_prio <= 1'b0;
        else if (i_adv) r_prio <= o_grant[0];
    end

endmodule

// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched: FIFO read side feeding a single output slot shared by two consumers
module fifo_rd_sched
    import fifo_rd_sched_pkg::*;
#(
    parameter int ASIZE = 4,
    parameter int DSIZE = 8
)
(
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [ASIZE:0]   rq2_wptr,
    output logic [ASIZE:0]   rptr,
    output logic [ASIZE-1:0] raddr,
    input  logic [DSIZE-1:0] rdata,
    input  logic [1:0]       c_req,
    output logic [1:0]       c_valid,
    output logic [DSIZE-1:0] c_data,
    output logic             rempty,
    output logic [ASIZE:0]   rlevel
);

    localparam int PW = ASIZE + 1;

    logic [ASIZE:0]   r_rbin;
    logic [ASIZE:0]   r_rptr;
    logic [1:0]       r_c_valid;
    logic [DSIZE-1:0] r_c_data;
    logic             r_rempty;
    logic [ASIZE:0]   r_rlevel;

    logic             w_hs;
    logic             w_pop;
    slot_e            w_slot;
    logic [1:0]       w_grant;
    logic [ASIZE:0]   w_rbin_next;
    logic [ASIZE:0]   w_rptr_next;
    logic [ASIZE:0]   w_wbin;

    rr_arb2 u_arb (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .i_req   (c_req),
        .i_adv   (w_pop),
        .o_grant (w_grant)
    );

    // Handshake frees the slot; a pop refills it in the same cycle when data and a requester exist
    always_comb begin
        w_hs        = |(r_c_valid & c_req);
        w_slot      = (|r_c_valid) ? SLOT_HOLD : SLOT_EMPTY;
        w_pop       = !r_rempty && (w_slot == SLOT_EMPTY || w_hs) && (|c_req);
        w_rbin_next = r_rbin + {{ASIZE{1'b0}}, w_pop};
        w_rptr_next = PW'(bin2gray(32'(w_rbin_next)));
        w_wbin      = PW'(gray2bin(32'(rq2_wptr)));
    end

    // Pointer, slot and status registers; status is computed from the post-pop pointer
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_rbin    <= '0;
            r_rptr    <= '0;
            r_c_valid <= '0;
            r_c_data  <= '0;
            r_rempty  <= 1'b1;
            r_rlevel  <= '0;
        end else begin
            r_rbin   <= w_rbin_next;
            r_rptr   <= w_rptr_next;
            r_rempty <= (w_rptr_next == rq2_wptr);
            r_rlevel <= w_wbin - w_rbin_next;
            if (w_pop) begin
                r_c_data  <= rdata;
                r_c_valid <= w_grant;
            end else if (w_hs) begin
                r_c_valid <= '0;
            end
        end
    end

    assign rptr    = r_rptr;
    assign raddr   = r_rbin[ASIZE-1:0];
    assign c_valid = r_c_valid;
    assign c_data  = r_c_data;
    assign rempty  = r_rempty;
    assign rlevel  = r_rlevel;

endmodule
